bp_table_sched: RTL and testbench
=================================

Name: bp_table_sched

Overview:
- Scheduler for a shared branch-prediction table: DEPTH = 2^IDX_W entries, indexed by branch number, each holding a last-outcome bit.
- Arbitrates the table's single access slot per cycle between fetch-side lookups and resolve-side outcome updates.
- Outcome updates are buffered in a small FIFO, and pending outcomes are forwarded to lookups.
- Keeps a saturating mismatch counter, counted when each update is committed.

Parameters:
- IDX_W, 4, branch-number width; table depth = 2^IDX_W.
- UQ_DEPTH, 4, update FIFO depth; power of two, ≥2.
- CNT_W, 16, mismatch counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- lk_valid  in  1  lookup request.
- lk_ready  out  1  lookup accepted when lk_valid && lk_ready.
- lk_branch  in  IDX_W  lookup index.
- pred_valid  out  1  one-cycle pulse: prediction result valid.
- pred_out  out  1  predicted outcome (1 = taken).
- pred_branch  out  IDX_W  index the result belongs to.
- up_valid  in  1  resolved-outcome update request.
- up_ready  out  1  update accepted when up_valid && up_ready.
- up_branch  in  IDX_W  update index.
- up_taken  in  1  actual outcome.
- clear_stats  in  1  synchronous clear of mismatch.
- mismatch  out  CNT_W  saturating count of committed mispredictions.
- uq_full  out  1  update FIFO full.
- uq_empty  out  1  update FIFO empty.

Behaviour:
- Reset (async assert, sync release):
  - All table entries = 0; FIFO emptied; arbiter in NORMAL.
  - pred_valid = 0, pred_out = 0, pred_branch = 0, mismatch = 0.
  - uq_empty = 1, uq_full = 0, lk_ready = 1, up_ready = 1.
  - Reset mid-operation discards all queued updates and any in-flight result.
- Table slot: exactly one operation per cycle, either a LOOKUP read or a COMMIT (FIFO head written to the table).
- Arbiter FSM:
  - NORMAL: lk_ready = 1. If lk_valid, the slot does LOOKUP. Otherwise, if the FIFO is non-empty, the slot does COMMIT.
  - NORMAL → DRAIN when occupancy reaches UQ_DEPTH at the clock edge.
  - DRAIN: lk_ready = 0; COMMIT every cycle.
  - DRAIN → NORMAL when occupancy ≤ UQ_DEPTH/2 after that edge.
- Lookup latency: 1 cycle. A lookup accepted in cycle N gives pred_valid = 1 in cycle N+1, with pred_branch = lk_branch.
- Forwarding:
  - pred_out = up_taken of the newest FIFO entry whose branch matches lk_branch (searched newest-first over valid entries).
  - If no entry matches, pred_out = the table entry.
  - An update accepted in the same cycle as a lookup is not visible to that lookup.
- Update FIFO:
  - up_ready = !uq_full, using registered occupancy.
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
  - Pointers wrap modulo UQ_DEPTH.
  - uq_full and uq_empty are registered flags that reflect occupancy after each edge.
- Commit: the head entry is written into the table.
  - If the stored prediction bit before the write ≠ up_taken, mismatch increments.
  - mismatch saturates at 2^CNT_W−1 and holds there.
- clear_stats: mismatch = 0 on the next edge. If a commit mismatch occurs in the same cycle, clear wins and the increment is dropped.
- Same-index commit and lookup cannot occur in one cycle, because there is a single slot.

Optional Feature:
- Macro: BP_SAT2_EN.
- With BP_SAT2_EN defined:
  - Each entry is a 2-bit saturating counter, reset value 01 (weakly not-taken).
  - Prediction bit = counter MSB.
  - Commit increments the counter on taken and decrements it on not-taken, saturating at 11 and 00.
  - The mismatch compare uses the MSB before update.
  - Forwarding returns the newest pending up_taken unchanged.
- Without the macro: entries are 1 bit, and a commit overwrites the entry with up_taken.

Test Plan:
- Reset, then lookup idx 5 → next cycle pred_valid = 1, pred_branch = 5, pred_out = 0; mismatch = 0, uq_empty = 1.
- Update (idx 3, taken) with no lookups → committed 1 cycle after push; mismatch = 1; later lookup idx 3 → pred_out = 1.
- Update (idx 7, taken), then continuous lookups of idx 7 → pred_out = 1 via forwarding while the entry is still queued; uq_empty stays 0.
- Four updates pushed while lk_valid is held high:
  - uq_full = 1 → DRAIN, lk_ready = 0 for 2 cycles, then lk_ready = 1 at occupancy 2.
  - up_ready = 0 while full.
- CNT_W = 2: five committed mispredictions → mismatch = 3 (saturated). clear_stats asserted in the same cycle as a mismatching commit → mismatch = 0.
- BP_SAT2_EN: commits of idx 2 taken, taken, not-taken → counter 01→10→11→10; lookup idx 2 → pred_out = 1; mismatch = 2 (first taken, final not-taken).

Source files
------------

// File: rtl/bp_table_sched.sv
// ---------------------------------------------------------------------------
// bp_table_sched
//
// Scheduler for a shared branch-prediction table (2^IDX_W entries). The table
// has a single access slot per cycle. Each cycle the slot does one of two
// things. It does a LOOKUP read for the fetch side, or it does a COMMIT. A
// COMMIT writes the oldest buffered resolve-side outcome into the table.
//
// Resolve-side outcomes are queued in a UQ_DEPTH-entry FIFO. Lookups see
// pending outcomes through forwarding: the newest matching entry wins. The
// block counts mispredictions at commit time in a saturating counter.
//
// Arbiter: in NORMAL, lookups take priority and commits use the idle
// slots. When the FIFO fills, the arbiter enters DRAIN. In DRAIN,
// lookups are blocked and a commit happens every cycle. The arbiter
// returns to NORMAL once occupancy has fallen to UQ_DEPTH/2.
//
// Handshakes: a transfer happens on a channel in any cycle where both valid
// and ready are high at the rising clock edge. Ready never depends on
// valid, because both ready outputs come straight from registers.
//
// Optional build macro: BP_SAT2_EN
//   defined   - each entry is a 2-bit saturating counter (reset 01).
//               The prediction is the counter's MSB.
//   undefined - each entry is a single last-outcome bit (reset 0).
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   lk_valid     in   lookup request
//   lk_ready     out  lookup slot available (low while draining)
//   lk_branch    in   lookup index
//   pred_valid   out  one-cycle pulse, prediction result valid
//   pred_out     out  predicted outcome (1 = taken)
//   pred_branch  out  index the prediction belongs to
//   up_valid     in   resolved-outcome update request
//   up_ready     out  update FIFO has room
//   up_branch    in   update index
//   up_taken     in   actual outcome
//   clear_stats  in   synchronous clear of mismatch (wins over increment)
//   mismatch     out  saturating count of committed mispredictions
//   uq_full      out  update FIFO full (registered)
//   uq_empty     out  update FIFO empty (registered)
// ---------------------------------------------------------------------------
module bp_table_sched #(
    parameter int IDX_W    = 4,
    parameter int UQ_DEPTH = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lk_valid,
    output logic             lk_ready,
    input  logic [IDX_W-1:0] lk_branch,
    output logic             pred_valid,
    output logic             pred_out,
    output logic [IDX_W-1:0] pred_branch,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [IDX_W-1:0] up_branch,
    input  logic             up_taken,
    input  logic             clear_stats,
    output logic [CNT_W-1:0] mismatch,
    output logic             uq_full,
    output logic             uq_empty
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int PW    = (UQ_DEPTH > 1) ? $clog2(UQ_DEPTH) : 1;
    localparam int CW    = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(UQ_DEPTH);
    localparam logic [CW-1:0] HALF_CNT = CW'(UQ_DEPTH / 2);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

`ifdef BP_SAT2_EN
    localparam int ENT_W = 2;
    localparam logic [ENT_W-1:0] ENT_RST = 2'b01;
`else
    localparam int ENT_W = 1;
    localparam logic [ENT_W-1:0] ENT_RST = 1'b0;
`endif

    typedef enum logic {
        ARB_NORMAL = 1'b0,
        ARB_DRAIN  = 1'b1
    } arb_state_t;

    arb_state_t state;

    // Prediction table and update FIFO storage
    logic [ENT_W-1:0] tbl      [DEPTH];
    logic [IDX_W-1:0] q_branch [UQ_DEPTH];
    logic             q_taken  [UQ_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    // Slot decisions for this cycle
    logic          do_lookup;
    logic          do_commit;
    logic          push;
    logic [CW-1:0] count_next;

    // lk_ready is low exactly when the arbiter is in DRAIN. That makes it
    // both the lookup handshake and the drain indicator.
    assign up_ready   = ~uq_full;
    assign do_lookup  = lk_valid & lk_ready;
    assign do_commit  = ~uq_empty & (~lk_ready | ~lk_valid);
    assign push       = up_valid & up_ready;
    assign count_next = count + CW'(push) - CW'(do_commit);

    // Forwarding: scan valid entries oldest to newest, so the last hit is the
    // newest. This cycle's push is not in storage yet, so it is not visible.
    logic fwd_hit;
    logic fwd_taken;
    logic [PW-1:0] fwd_slot;

    always_comb begin
        fwd_hit   = 1'b0;
        fwd_taken = 1'b0;
        fwd_slot  = '0;
        for (int i = 0; i < UQ_DEPTH; i++) begin
            fwd_slot = rd_ptr + PW'(i);
            if ((CW'(i) < count) && (q_branch[fwd_slot] == lk_branch)) begin
                fwd_hit   = 1'b1;
                fwd_taken = q_taken[fwd_slot];
            end
        end
    end

    logic lookup_bit;
    assign lookup_bit = fwd_hit ? fwd_taken : tbl[lk_branch][ENT_W-1];

    // Commit of the FIFO head
    logic [IDX_W-1:0] head_branch;
    logic             head_taken;
    logic [ENT_W-1:0] head_entry;
    logic [ENT_W-1:0] new_entry;
    logic             commit_miss;

    assign head_branch = q_branch[rd_ptr];
    assign head_taken  = q_taken[rd_ptr];
    assign head_entry  = tbl[head_branch];
    assign commit_miss = head_entry[ENT_W-1] != head_taken;

`ifdef BP_SAT2_EN
    always_comb begin
        new_entry = head_entry;
        if (head_taken) begin
            if (head_entry != 2'b11) new_entry = head_entry + 2'b01;
        end else begin
            if (head_entry != 2'b00) new_entry = head_entry - 2'b01;
        end
    end
`else
    assign new_entry = head_taken;
`endif

    // Arbiter FSM. lk_ready is registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ARB_NORMAL;
            lk_ready <= 1'b1;
        end else begin
            case (state)
                ARB_NORMAL: begin
                    if (count_next == FULL_CNT) begin
                        state    <= ARB_DRAIN;
                        lk_ready <= 1'b0;
                    end
                end
                ARB_DRAIN: begin
                    if (count_next <= HALF_CNT) begin
                        state    <= ARB_NORMAL;
                        lk_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= ARB_NORMAL;
                    lk_ready <= 1'b1;
                end
            endcase
        end
    end

    // Update FIFO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            uq_full  <= 1'b0;
            uq_empty <= 1'b1;
            for (int i = 0; i < UQ_DEPTH; i++) begin
                q_branch[i] <= '0;
                q_taken[i]  <= 1'b0;
            end
        end else begin
            if (push) begin
                q_branch[wr_ptr] <= up_branch;
                q_taken[wr_ptr]  <= up_taken;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (do_commit) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count    <= count_next;
            uq_full  <= (count_next == FULL_CNT);
            uq_empty <= (count_next == '0);
        end
    end

    // Prediction table
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= ENT_RST;
            end
        end else if (do_commit) begin
            tbl[head_branch] <= new_entry;
        end
    end

    // Lookup result, one cycle after acceptance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pred_valid  <= 1'b0;
            pred_out    <= 1'b0;
            pred_branch <= '0;
        end else begin
            pred_valid <= do_lookup;
            if (do_lookup) begin
                pred_out    <= lookup_bit;
                pred_branch <= lk_branch;
            end
        end
    end

    // Mismatch statistics; a clear drops a same-cycle increment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mismatch <= '0;
        end else if (clear_stats) begin
            mismatch <= '0;
        end else if (do_commit && commit_miss && (mismatch != CNT_MAX)) begin
            mismatch <= mismatch + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_bp_table_sched.sv
// ---------------------------------------------------------------------------
// tb_bp_table_sched
//
// Two instances of bp_table_sched share every input. The first uses the
// default 16-bit mismatch counter. The second uses CNT_W = 2, so it reaches
// saturation.
//
// The reference model holds the pending updates in a queue and the table in
// an int array. It applies the slot, forwarding, drain and statistics rules
// once per cycle. Build with +define+BP_SAT2_EN to check the counter variant.
// ---------------------------------------------------------------------------
module tb_bp_table_sched;

    localparam int UQD = 4;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- DUT signals ----------------
    logic       lk_valid, up_valid, up_taken, clear_stats;
    logic [3:0] lk_branch, up_branch;

    logic        lk_ready, pred_valid, pred_out, up_ready, uq_full, uq_empty;
    logic [3:0]  pred_branch;
    logic [15:0] mismatch;

    logic       s_lk_ready, s_pred_valid, s_pred_out, s_up_ready, s_uq_full, s_uq_empty;
    logic [3:0] s_pred_branch;
    logic [1:0] s_mismatch;

    bp_table_sched #(.IDX_W(4), .UQ_DEPTH(UQD), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_branch(lk_branch),
        .pred_valid(pred_valid), .pred_out(pred_out), .pred_branch(pred_branch),
        .up_valid(up_valid), .up_ready(up_ready), .up_branch(up_branch), .up_taken(up_taken),
        .clear_stats(clear_stats), .mismatch(mismatch),
        .uq_full(uq_full), .uq_empty(uq_empty)
    );

    bp_table_sched #(.IDX_W(4), .UQ_DEPTH(UQD), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset),
        .lk_valid(lk_valid), .lk_ready(s_lk_ready), .lk_branch(lk_branch),
        .pred_valid(s_pred_valid), .pred_out(s_pred_out), .pred_branch(s_pred_branch),
        .up_valid(up_valid), .up_ready(s_up_ready), .up_branch(up_branch), .up_taken(up_taken),
        .clear_stats(clear_stats), .mismatch(s_mismatch),
        .uq_full(s_uq_full), .uq_empty(s_uq_empty)
    );

    // ---------------- scoreboard / checker ----------------
    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [3:0] br;
        logic       tk;
    } upd_t;

    upd_t       pend_q[$];   // outcomes accepted but not yet in the table
    logic [4:0] exp_q[$];    // expected {branch, prediction} per accepted lookup
    int         m_tbl[16];
    int         m_miss;      // unbounded; each instance saturates at its own width
    bit         m_drain;

    function automatic int ent_reset();
`ifdef BP_SAT2_EN
        return 1;
`else
        return 0;
`endif
    endfunction

    function automatic bit pred_bit(input int e);
`ifdef BP_SAT2_EN
        return bit'((e >> 1) & 1);
`else
        return bit'(e & 1);
`endif
    endfunction

    function automatic int ent_update(input int e, input bit tk);
`ifdef BP_SAT2_EN
        if (tk) return (e < 3) ? e + 1 : 3;
        return (e > 0) ? e - 1 : 0;
`else
        return tk ? 1 : 0;
`endif
    endfunction

    function automatic int sat_to(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        pend_q.delete();
        exp_q.delete();
        for (int i = 0; i < 16; i++) m_tbl[i] = ent_reset();
        m_miss  = 0;
        m_drain = 1'b0;
    endtask

    task automatic compare_outputs(input bit lk);
        logic [4:0] e;
        check("pred_valid", pred_valid, lk);
        if (lk) begin
            e = exp_q.pop_front();
            check("pred_branch", pred_branch, e[4:1]);
            check("pred_out", pred_out, e[0]);
        end
        check("mismatch", mismatch, sat_to(m_miss, 65535));
        check("mismatch_sat", s_mismatch, sat_to(m_miss, 3));
        check("uq_full", uq_full, pend_q.size() == UQD);
        check("uq_empty", uq_empty, pend_q.size() == 0);
        check("lk_ready", lk_ready, !m_drain);
        check("up_ready", up_ready, pend_q.size() < UQD);
    endtask

    // One clock: the model consumes the inputs currently driven, then the DUT
    // is sampled 1 time unit after the edge.
    task automatic step();
        bit   lk, cm, pu, p;
        upd_t u;
        lk = lk_valid && !m_drain;
        cm = !lk && (pend_q.size() > 0) && (m_drain || !lk_valid);
        pu = up_valid && (pend_q.size() < UQD);
        if (lk) begin
            p = pred_bit(m_tbl[lk_branch]);
            for (int i = 0; i < pend_q.size(); i++)
                if (pend_q[i].br == lk_branch) p = pend_q[i].tk;
            exp_q.push_back({lk_branch, p});
        end
        if (cm) begin
            u = pend_q.pop_front();
            if (pred_bit(m_tbl[u.br]) != u.tk) m_miss++;
            m_tbl[u.br] = ent_update(m_tbl[u.br], u.tk);
        end
        if (clear_stats) m_miss = 0;
        if (pu) begin
            u.br = up_branch;
            u.tk = up_taken;
            pend_q.push_back(u);
        end
        if (!m_drain && pend_q.size() == UQD) m_drain = 1'b1;
        else if (m_drain && pend_q.size() <= UQD / 2) m_drain = 1'b0;
        @(posedge clk);
        #1;
        compare_outputs(lk);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit lv, input int lb, input bit uv, input int ub,
                         input bit ut, input bit cs);
        lk_valid    = lv;
        lk_branch   = 4'(lb);
        up_valid    = uv;
        up_branch   = 4'(ub);
        up_taken    = ut;
        clear_stats = cs;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic apply_reset();
        #2;
        reset = 1'b0;            // asserted between edges: asynchronous
        model_reset();
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        apply_reset();

        // Reset values
        check("rst_pred_valid", pred_valid, 0);
        check("rst_pred_out", pred_out, 0);
        check("rst_pred_branch", pred_branch, 0);
        check("rst_mismatch", mismatch, 0);
        check("rst_uq_empty", uq_empty, 1);
        check("rst_uq_full", uq_full, 0);
        check("rst_lk_ready", lk_ready, 1);
        check("rst_up_ready", up_ready, 1);

        // Lookup idx 5 straight after reset
        drive(1, 5, 0, 0, 0, 0);
        step();
        check("tp1_valid", pred_valid, 1);
        check("tp1_branch", pred_branch, 5);
        check("tp1_out", pred_out, 0);

        // Update idx 3 taken, committed on the following idle cycle
        drive(0, 0, 1, 3, 1, 0);
        step();
        idle(1);
        check("tp2_mismatch", mismatch, 1);
        check("tp2_empty", uq_empty, 1);
        drive(1, 3, 0, 0, 0, 0);
        step();
        check("tp2_out", pred_out, 1);

        // Update idx 7 taken alongside lookups of 7: forwarded while queued
        drive(1, 7, 1, 7, 1, 0);
        step();
        check("tp3_same_cycle", pred_out, 0);
        drive(1, 7, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("tp3_fwd", pred_out, 1);
            check("tp3_not_empty", uq_empty, 0);
        end
        idle(3);

        // Fill the FIFO while lookups hold the slot, then drain
        for (int i = 0; i < 4; i++) begin
            drive(1, 9, 1, 8 + i, i[0], 0);
            step();
        end
        check("tp4_full", uq_full, 1);
        check("tp4_drain", lk_ready, 0);
        check("tp4_up_ready", up_ready, 0);
        drive(1, 9, 0, 0, 0, 0);
        step();
        check("tp4_drain2", lk_ready, 0);
        step();
        check("tp4_normal", lk_ready, 1);
        idle(3);

        // Saturation of the 2-bit counter, then clear beating a mismatch
        drive(0, 0, 0, 0, 0, 1);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 12, (i % 2) == 0, 0);
            step();
            idle(1);
        end
        check("tp5_sat", s_mismatch, 3);
        check("tp5_wide", mismatch, 5);
        drive(0, 0, 1, 12, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 1);
        step();
        check("tp5_clear", mismatch, 0);
        check("tp5_clear_sat", s_mismatch, 0);

        // idx 2: taken, taken, not-taken
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 2, i < 2, 0);
            step();
            idle(1);
        end
        drive(1, 2, 0, 0, 0, 0);
        step();
`ifdef BP_SAT2_EN
        check("tp6_out", pred_out, 1);
`else
        check("tp6_out", pred_out, 0);
`endif
        check("tp6_mismatch", mismatch, 2);

        // Reset with updates queued discards them
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 4 + i, 1, 0);
            step();
        end
        apply_reset();
        check("rst2_empty", uq_empty, 1);
        check("rst2_mismatch", mismatch, 0);
        drive(1, 4, 0, 0, 0, 0);
        step();
        check("rst2_out", pred_out, 0);

        // Randomized traffic
        for (int c = 0; c < 2500; c++) begin
            int rb_l, rb_u;
            rb_l = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 15);
            rb_u = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 15);
            drive($urandom_range(0, 99) < 55, rb_l,
                  $urandom_range(0, 99) < 60, rb_u,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 99) < 3);
            step();
            if (c == 1200) apply_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
